sys_bus_router: RTL and testbench

- Parametrised single-master, N-slave memory-bus router. It sits between the LSU memory-side port and N data-memory-style slaves (data memory, peripherals), each slave using a req/we/be/addr/wd/rd/ready handshake.
- Decodes the request address to one slave and registers the transaction.
- Holds the slave request until the slave reports ready, then returns a one-cycle response to the master.
- Generates error responses for unmapped addresses and for slaves that time out.

---
 rtl/sys_bus_pkg.sv | 21 ++
 rtl/sys_bus_decoder.sv | 18 +
 rtl/sys_bus_router.sv | 151 +++++++++++++++
 tb/tb_sys_bus_router.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types, address-field positions and helpers for the single-master,
// N-slave memory-bus router.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 24;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Slaves see only the low 24 bits; the select byte is stripped off.
  function automatic logic [31:0] local_addr(input logic [31:0] addr);
    return {8'h00, addr[23:0]};
  endfunction

endpackage

// File: rtl/sys_bus_decoder.sv
// Combinational address decode: slave select byte, in-range flag and the
// slave-local address.
import sys_bus_pkg::*;

module sys_bus_decoder #(
  parameter int N_SLAVES = 4
) (
  input  logic [31:0] addr,
  output logic [7:0]  sel,
  output logic        valid,
  output logic [31:0] offset
);

  assign sel    = addr[SEL_MSB:SEL_LSB];
  assign valid  = (32'(sel) < 32'(N_SLAVES));
  assign offset = local_addr(addr);

endmodule

// File: rtl/sys_bus_router.sv
// Single-master to N-slave bus router: decodes, holds the slave request until
// ready or timeout, and returns a one-cycle response (error on unmapped/timeout).
import sys_bus_pkg::*;

module sys_bus_router #(
  parameter int          N_SLAVES       = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_req_i,
  input  logic                  m_we_i,
  input  logic [3:0]            m_be_i,
  input  logic [31:0]           m_addr_i,
  input  logic [31:0]           m_wd_i,
  output logic [31:0]           m_rd_o,
  output logic                  m_ready_o,
  output logic                  m_err_o,
  output logic                  m_busy_o,
  output logic [N_SLAVES-1:0]   s_req_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wd_o,
  input  logic [32*N_SLAVES-1:0] s_rd_i,
  input  logic [N_SLAVES-1:0]   s_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0]    sel_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;
  logic [31:0]   rd_q;
  logic          err_q;

  logic [7:0]    dec_sel;
  logic          dec_valid;
  logic [31:0]   dec_offset;
  logic          sel_ready;
  logic [31:0]   sel_rd;
  logic          expired;

  sys_bus_decoder #(.N_SLAVES(N_SLAVES)) u_decoder (
    .addr   (m_addr_i),
    .sel    (dec_sel),
    .valid  (dec_valid),
    .offset (dec_offset)
  );

  // Only the selected slave's ready and read-data slice are visible to the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rd    = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == 8'(k)) begin
        sel_ready = s_ready_i[k];
        sel_rd    = s_rd_i[32*k +: 32];
      end
    end
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (m_req_i) state_nx = dec_valid ? BUSY : RESP;
      BUSY:    if (sel_ready || expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_req_o   = '0;
    m_ready_o = 1'b0;
    m_err_o   = 1'b0;
    m_busy_o  = (state != IDLE);
    case (state)
      BUSY: begin
        for (int k = 0; k < N_SLAVES; k++) s_req_o[k] = (sel_q == 8'(k));
      end
      RESP: begin
        m_ready_o = 1'b1;
        m_err_o   = err_q;
      end
      default: ;
    endcase
  end

  // Ready has priority over expiry on the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req_i) begin
            sel_q  <= dec_sel;
            we_q   <= m_we_i;
            be_q   <= m_be_i;
            addr_q <= dec_offset;
            wd_q   <= m_wd_i;
            cnt    <= '0;
            if (!dec_valid) begin
              err_q <= 1'b1;
              rd_q  <= ERR_RDATA;
            end
          end
        end
        BUSY: begin
          if (sel_ready) begin
            rd_q  <= sel_rd;
            err_q <= 1'b0;
          end else if (expired) begin
            rd_q  <= ERR_RDATA;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m_rd_o   = rd_q;
  assign s_we_o   = we_q;
  assign s_be_o   = be_q;
  assign s_addr_o = addr_q;
  assign s_wd_o   = wd_q;

endmodule

// File: tb/tb_sys_bus_router.sv
// Scoreboard bench for sys_bus_router: a driver issues transactions and pushes
// the expected response; a monitor pops and compares on every m_ready_o.
module tb_sys_bus_router;

  localparam int          N      = 4;
  localparam int          T      = 8;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             m_req_i;
  logic             m_we_i;
  logic [3:0]       m_be_i;
  logic [31:0]      m_addr_i;
  logic [31:0]      m_wd_i;
  logic [31:0]      m_rd_o;
  logic             m_ready_o;
  logic             m_err_o;
  logic             m_busy_o;
  logic [N-1:0]     s_req_o;
  logic             s_we_o;
  logic [3:0]       s_be_o;
  logic [31:0]      s_addr_o;
  logic [31:0]      s_wd_o;
  logic [32*N-1:0]  s_rd_i;
  logic [N-1:0]     s_ready_i;

  always #5 clk_i = ~clk_i;

  sys_bus_router #(.N_SLAVES(N), .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR_RD)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_be_i    (m_be_i),
    .m_addr_i  (m_addr_i),
    .m_wd_i    (m_wd_i),
    .m_rd_o    (m_rd_o),
    .m_ready_o (m_ready_o),
    .m_err_o   (m_err_o),
    .m_busy_o  (m_busy_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wd_o    (s_wd_o),
    .s_rd_i    (s_rd_i),
    .s_ready_i (s_ready_i)
  );

  typedef struct {
    int          sel;
    logic        we;
    logic [3:0]  be;
    logic [31:0] laddr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Behaviour of the slave currently addressed: ready after cur_wait cycles.
  int          cur_sel  = 0;
  int          cur_wait = 0;
  logic [31:0] cur_data = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // Slave responder; non-selected slaves toggle ready randomly.
  initial begin
    int bcnt;
    logic [N-1:0] rdy;
    logic [31:0] word;
    bcnt = 0;
    s_ready_i = '0;
    s_rd_i = '0;
    forever begin
      @(negedge clk_i);
      rdy = N'($urandom);
      if (s_req_o != '0) begin
        if (cur_sel < N) rdy[cur_sel] = (bcnt == cur_wait);
        bcnt++;
      end else begin
        bcnt = 0;
        if (cur_sel < N) rdy[cur_sel] = 1'b0;
      end
      s_ready_i = rdy;
      for (int k = 0; k < N; k++) begin
        word = $urandom;
        if (k == cur_sel) word = cur_data;
        s_rd_i[32*k +: 32] = word;
      end
    end
  end

  // Monitor: checks slave-side fields during BUSY and every response.
  initial begin
    logic prev_busy;
    int acc;
    logic [31:0] last_rd;
    logic [N-1:0] er;
    exp_t e;
    prev_busy = 1'b0;
    acc = 0;
    last_rd = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_busy = 1'b0;
        last_rd = '0;
        continue;
      end
      if (m_busy_o && !prev_busy) acc = cyc;
      prev_busy = m_busy_o;
      if (s_req_o != '0) begin
        if (sbq.size() == 0) check("sreq_without_txn", 32'(s_req_o), 0);
        else begin
          e = sbq[0];
          er = '0;
          if (e.sel < N) er[e.sel] = 1'b1;
          check("s_req", 32'(s_req_o), 32'(er));
          check("s_we", 32'(s_we_o), 32'(e.we));
          check("s_be", 32'(s_be_o), 32'(e.be));
          check("s_addr", s_addr_o, e.laddr);
          check("s_wd", s_wd_o, e.wd);
        end
      end
      if (m_ready_o) begin
        if (sbq.size() == 0) check("spurious_ready", 32'(m_ready_o), 0);
        else begin
          e = sbq.pop_front();
          check("m_err", 32'(m_err_o), 32'(e.err));
          check("m_rd", m_rd_o, e.rd);
          check("latency", 32'(cyc - acc + 1), 32'(e.lat));
          last_rd = e.rd;
        end
      end else begin
        check("m_err_idle", 32'(m_err_o), 0);
        check("m_rd_hold", m_rd_o, last_rd);
      end
    end
  end

  task automatic issue(input int sel, input logic we, input logic [3:0] be,
                       input logic [23:0] off, input logic [31:0] wd,
                       input int w, input logic [31:0] data);
    exp_t e;
    int g;
    e.sel = sel; e.we = we; e.be = be; e.laddr = {8'h00, off}; e.wd = wd;
    if (sel >= N)     begin e.err = 1'b1; e.rd = ERR_RD; e.lat = 1;     end
    else if (w < T)   begin e.err = 1'b0; e.rd = data;   e.lat = w + 2; end
    else              begin e.err = 1'b1; e.rd = ERR_RD; e.lat = T + 1; end
    cur_sel = sel; cur_wait = w; cur_data = data;
    m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = {sel[7:0], off}; m_wd_i = wd;
    sbq.push_back(e);
    g = 0;
    do begin @(negedge clk_i); g++; end while (!m_busy_o && g < 5);
    check("accepted", 32'(m_busy_o), 1);
    // Master port is noise while busy; the router must ignore it.
    g = 0;
    while (!m_ready_o && g < T + 12) begin
      m_req_i = 1'($urandom); m_we_i = 1'($urandom); m_be_i = 4'($urandom);
      m_addr_i = $urandom; m_wd_i = $urandom;
      @(negedge clk_i);
      g++;
    end
    check("resp_seen", 32'(m_ready_o), 1);
  endtask

  task automatic idle(input int n);
    m_req_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic reset_mid_busy();
    int g;
    cur_sel = 1; cur_wait = 100; cur_data = 32'h0BAD_0BAD;
    m_req_i = 1'b1; m_we_i = 1'b0; m_be_i = 4'hF; m_addr_i = 32'h0100_0020; m_wd_i = '0;
    sbq.push_back('{sel: 1, we: 1'b0, be: 4'hF, laddr: 32'h0000_0020, wd: 32'h0,
                    err: 1'b0, rd: 32'h0, lat: 0});
    g = 0;
    do begin @(negedge clk_i); g++; end while (!m_busy_o && g < 5);
    m_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_sreq", 32'(s_req_o), 0);
    check("rst_async_busy", 32'(m_busy_o), 0);
    check("rst_async_ready", 32'(m_ready_o), 0);
    sbq.delete();
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, w, r;
    rst_i = 1'b1;
    m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = '0; m_addr_i = '0; m_wd_i = '0;
    #1;
    check("rst_m_rd", m_rd_o, 0);
    check("rst_m_ready", 32'(m_ready_o), 0);
    check("rst_m_err", 32'(m_err_o), 0);
    check("rst_m_busy", 32'(m_busy_o), 0);
    check("rst_s_req", 32'(s_req_o), 0);
    check("rst_s_we", 32'(s_we_o), 0);
    check("rst_s_be", 32'(s_be_o), 0);
    check("rst_s_addr", s_addr_o, 0);
    check("rst_s_wd", s_wd_o, 0);
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);

    issue(1, 1'b0, 4'hF, 24'h000010, 32'h0, 3, 32'h1234_5678);          idle(1);
    issue(0, 1'b1, 4'b0011, 24'h000004, 32'hA5A5_5A5A, 0, $urandom);    idle(1);
    issue(5, 1'b0, 4'hF, 24'h000000, 32'h0, 0, $urandom);               idle(1);
    issue(2, 1'b0, 4'hF, 24'h000000, 32'h0, 100, $urandom);             idle(1);
    issue(2, 1'b0, 4'hF, 24'h000100, 32'h0, T - 1, 32'hCAFE_0002);      idle(0);
    issue(3, 1'b0, 4'hF, 24'h000200, 32'h0, 0, 32'h3333_0003);          idle(0);
    issue(1, 1'b1, 4'hC, 24'h000300, 32'h1111_2222, 1, 32'h1111_0001);  idle(1);
    reset_mid_busy();
    @(negedge clk_i);
    issue(0, 1'b0, 4'hF, 24'h000040, 32'h0, 2, 32'h0000_AAAA);          idle(1);

    for (int i = 0; i < 80; i++) begin
      sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, 255)) : int'($urandom_range(0, N - 1));
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 3);
      else if (r < 8) w = $urandom_range(4, T - 1);
      else            w = $urandom_range(T, T + 3);
      issue(sel, 1'($urandom), 4'($urandom), 24'($urandom), $urandom, w, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("queue_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
